// File: rtl/rpn_stack_alu.sv
// RPN calculator core: a DEPTH x WIDTH operand stack driven by a two-state
// accept/execute controller, with sticky error flags for stack and arithmetic faults.
module rpn_stack_alu #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [CW-1:0]    count,
  output logic             err_over,
  output logic             err_under,
  output logic             err_ovf,
  output logic             err_illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [3:0] OP_PUSH  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NEG   = 4'd7;
  localparam logic [3:0] OP_DUP   = 4'd8;
  localparam logic [3:0] OP_SWAP  = 4'd9;
  localparam logic [3:0] OP_DROP  = 4'd10;
  localparam logic [3:0] OP_CLEAR = 4'd11;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       state;
  logic [3:0]       op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    idx_a, idx_b, idx_push;
  logic [WIDTH-1:0] a, b;
  logic             has1, has2, full;

  // Stack grows upward: entry count-1 is the top, count-2 the one below.
  assign idx_a    = AW'(count - CW'(1));
  assign idx_b    = AW'(count - CW'(2));
  assign idx_push = AW'(count);

  assign has1 = (count != '0);
  assign has2 = (count >= CW'(2));
  assign full = (count == CW'(DEPTH));

  assign a     = has1 ? mem[idx_a] : '0;
  assign b     = has2 ? mem[idx_b] : '0;
  assign top   = a;
  assign next  = b;
  assign ready = (state == S_IDLE);

  // Binary ALU on B (next) and A (top), with signed-overflow detection.
  logic [WIDTH:0]         sum_ext, diff_ext;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       bin_res;
  logic                   bin_ovf;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    bin_res  = '0;
    bin_ovf  = 1'b0;
    sum_ext  = {b[WIDTH-1], b} + {a[WIDTH-1], a};
    diff_ext = {b[WIDTH-1], b} - {a[WIDTH-1], a};
    prod     = $signed({{WIDTH{b[WIDTH-1]}}, b}) * $signed({{WIDTH{a[WIDTH-1]}}, a});
    case (op)
      OP_ADD: begin
        bin_res = sum_ext[WIDTH-1:0];
        bin_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
      end
      OP_SUB: begin
        bin_res = diff_ext[WIDTH-1:0];
        bin_ovf = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
      end
      OP_MUL: begin
        bin_res = prod[WIDTH-1:0];
        bin_ovf = (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});
      end
      OP_AND:  bin_res = b & a;
      OP_OR:   bin_res = b | a;
      OP_XOR:  bin_res = b ^ a;
      default: bin_res = '0;
    endcase
  end

  // Command decode: up to two stack writes, the next count, and flag updates.
  logic             wr_a_en, wr_b_en;
  logic [AW-1:0]    wr_a_idx, wr_b_idx;
  logic [WIDTH-1:0] wr_a_data, wr_b_data;
  logic [CW-1:0]    count_nxt;
  logic             set_over, set_under, set_ovf, set_illegal, clear_flags;

  always_comb begin
    wr_a_en     = 1'b0;
    wr_a_idx    = idx_a;
    wr_a_data   = '0;
    wr_b_en     = 1'b0;
    wr_b_idx    = idx_b;
    wr_b_data   = '0;
    count_nxt   = count;
    set_over    = 1'b0;
    set_under   = 1'b0;
    set_ovf     = 1'b0;
    set_illegal = 1'b0;
    clear_flags = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) begin
          set_over = 1'b1;
        end else begin
          wr_a_en   = 1'b1;
          wr_a_idx  = idx_push;
          wr_a_data = operand;
          count_nxt = count + CW'(1);
        end
      end
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
        if (!has2) begin
          set_under = 1'b1;
        end else begin
          wr_b_en   = 1'b1;
          wr_b_data = bin_res;
          set_ovf   = bin_ovf;
          count_nxt = count - CW'(1);
        end
      end
      OP_NEG: begin
        if (!has1) begin
          set_under = 1'b1;
        end else begin
          wr_a_en   = 1'b1;
          wr_a_data = '0 - a;
          set_ovf   = (a == MIN_NEG);
        end
      end
      OP_DUP: begin
        if (!has1) begin
          set_under = 1'b1;
        end else if (full) begin
          set_over = 1'b1;
        end else begin
          wr_a_en   = 1'b1;
          wr_a_idx  = idx_push;
          wr_a_data = a;
          count_nxt = count + CW'(1);
        end
      end
      OP_SWAP: begin
        if (!has2) begin
          set_under = 1'b1;
        end else begin
          wr_a_en   = 1'b1;
          wr_a_data = b;
          wr_b_en   = 1'b1;
          wr_b_data = a;
        end
      end
      OP_DROP: begin
        if (!has1) set_under = 1'b1;
        else       count_nxt = count - CW'(1);
      end
      OP_CLEAR: begin
        count_nxt   = '0;
        clear_flags = 1'b1;
      end
      default: set_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= S_IDLE;
      done        <= 1'b0;
      count       <= '0;
      op          <= '0;
      operand     <= '0;
      err_over    <= 1'b0;
      err_under   <= 1'b0;
      err_ovf     <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (cmd_valid) begin
          op      <= cmd;
          operand <= data_in;
          state   <= S_EXEC;
        end
      end else begin
        state <= S_IDLE;
        done  <= 1'b1;
        count <= count_nxt;
        if (clear_flags) begin
          err_over    <= 1'b0;
          err_under   <= 1'b0;
          err_ovf     <= 1'b0;
          err_illegal <= 1'b0;
        end else begin
          err_over    <= err_over    | set_over;
          err_under   <= err_under   | set_under;
          err_ovf     <= err_ovf     | set_ovf;
          err_illegal <= err_illegal | set_illegal;
        end
      end
    end
  end

  // NOTE: the stack array has no reset; count alone decides which entries are valid.
  always_ff @(posedge CLOCK_50) begin
    if (!reset && state == S_EXEC) begin
      if (wr_a_en) mem[wr_a_idx] <= wr_a_data;
      if (wr_b_en) mem[wr_b_idx] <= wr_b_data;
    end
  end

endmodule

// File: tb/tb_rpn_stack_alu.sv
// Directed bench for rpn_stack_alu (WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_rpn_stack_alu;

  localparam logic [3:0] OP_PUSH  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_NEG   = 4'd7;
  localparam logic [3:0] OP_DUP   = 4'd8;
  localparam logic [3:0] OP_SWAP  = 4'd9;
  localparam logic [3:0] OP_DROP  = 4'd10;
  localparam logic [3:0] OP_CLEAR = 4'd11;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic [7:0] data_in;
  logic       ready, done;
  logic [7:0] stack_top, stack_next;
  logic [2:0] count;
  logic       err_over, err_under, err_ovf, err_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  rpn_stack_alu #(.WIDTH(8), .DEPTH(4)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .data_in    (data_in),
    .ready      (ready),
    .done       (done),
    .top        (stack_top),
    .next       (stack_next),
    .count      (count),
    .err_over   (err_over),
    .err_under  (err_under),
    .err_ovf    (err_ovf),
    .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one command and checks the two-cycle accept/execute/done timing.
  task automatic issue(input logic [3:0] c, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    data_in   = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL exec_phase cmd=%0d: done=%b ready=%b, want done=0 ready=0", c, done, ready);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL done_pulse cmd=%0d: done=%b ready=%b, want done=1 ready=1", c, done, ready);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 4'd0;
    data_in   = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0 || count !== 3'd0 || stack_top !== 8'h00 ||
        stack_next !== 8'h00 || {err_over, err_under, err_ovf, err_illegal} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b done=%b count=%0d top=%h next=%h flags=%b%b%b%b, want 1 0 0 00 00 0000",
               ready, done, count, stack_top, stack_next, err_over, err_under, err_ovf, err_illegal);
    end
  endtask

  task automatic test_add_overflow;
    issue(OP_PUSH, 8'hA9);
    issue(OP_PUSH, 8'hA9);
    n_cmp++;
    if (stack_top !== 8'hA9 || stack_next !== 8'hA9 || count !== 3'd2) begin
      n_bad++;
      $display("FAIL push_two: top=%h next=%h count=%0d, want A9 A9 2", stack_top, stack_next, count);
    end
    issue(OP_ADD, 8'h00);
    n_cmp++;
    if (stack_top !== 8'h52 || stack_next !== 8'h00 || count !== 3'd1 || err_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL add_wrap: top=%h next=%h count=%0d ovf=%b, want 52 00 1 1",
               stack_top, stack_next, count, err_ovf);
    end
  endtask

  task automatic test_arith;
    issue(OP_CLEAR, 8'h00);
    n_cmp++;
    if (count !== 3'd0 || err_ovf !== 1'b0 || stack_top !== 8'h00) begin
      n_bad++;
      $display("FAIL clear_after_add: count=%0d ovf=%b top=%h, want 0 0 00", count, err_ovf, stack_top);
    end
    issue(OP_PUSH, 8'h07);
    issue(OP_PUSH, 8'h03);
    issue(OP_SUB, 8'h00);
    n_cmp++;
    if (stack_top !== 8'h04 || count !== 3'd1 || err_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL sub: top=%h count=%0d ovf=%b, want 04 1 0", stack_top, count, err_ovf);
    end
    issue(OP_PUSH, 8'h05);
    issue(OP_MUL, 8'h00);
    n_cmp++;
    if (stack_top !== 8'h14 || count !== 3'd1 || err_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL mul: top=%h count=%0d ovf=%b, want 14 1 0", stack_top, count, err_ovf);
    end
    issue(OP_NEG, 8'h00);
    n_cmp++;
    if (stack_top !== 8'hEC || count !== 3'd1 || err_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL neg: top=%h count=%0d ovf=%b, want EC 1 0", stack_top, count, err_ovf);
    end
    // 0x80 has no positive counterpart in 8 bits: wraps to itself and flags overflow.
    issue(OP_PUSH, 8'h80);
    issue(OP_NEG, 8'h00);
    n_cmp++;
    if (stack_top !== 8'h80 || stack_next !== 8'hEC || count !== 3'd2 || err_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL neg_min: top=%h next=%h count=%0d ovf=%b, want 80 EC 2 1",
               stack_top, stack_next, count, err_ovf);
    end
  endtask

  task automatic test_bounds;
    issue(OP_CLEAR, 8'h00);
    for (int i = 1; i <= 4; i++) issue(OP_PUSH, 8'(i));
    issue(OP_PUSH, 8'h05);
    n_cmp++;
    if (err_over !== 1'b1 || count !== 3'd4 || stack_top !== 8'h04 || stack_next !== 8'h03) begin
      n_bad++;
      $display("FAIL push_full: over=%b count=%0d top=%h next=%h, want 1 4 04 03",
               err_over, count, stack_top, stack_next);
    end
    issue(OP_DUP, 8'h00);
    n_cmp++;
    if (count !== 3'd4 || stack_top !== 8'h04 || stack_next !== 8'h03 || err_under !== 1'b0) begin
      n_bad++;
      $display("FAIL dup_full: count=%0d top=%h next=%h under=%b, want 4 04 03 0",
               count, stack_top, stack_next, err_under);
    end
    for (int i = 0; i < 4; i++) issue(OP_DROP, 8'h00);
    n_cmp++;
    if (count !== 3'd0 || stack_top !== 8'h00 || err_under !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_all: count=%0d top=%h under=%b, want 0 00 0", count, stack_top, err_under);
    end
    issue(OP_DROP, 8'h00);
    n_cmp++;
    if (err_under !== 1'b1 || count !== 3'd0 || stack_top !== 8'h00 || err_over !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_empty: under=%b count=%0d top=%h over=%b, want 1 0 00 1",
               err_under, count, stack_top, err_over);
    end
  endtask

  task automatic test_swap_illegal;
    issue(OP_CLEAR, 8'h00);
    n_cmp++;
    if ({err_over, err_under, err_ovf, err_illegal} !== 4'b0000 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL clear_flags: flags=%b%b%b%b count=%0d, want 0000 0",
               err_over, err_under, err_ovf, err_illegal, count);
    end
    issue(OP_PUSH, 8'h11);
    issue(OP_PUSH, 8'h22);
    issue(OP_SWAP, 8'h00);
    n_cmp++;
    if (stack_top !== 8'h11 || stack_next !== 8'h22 || count !== 3'd2) begin
      n_bad++;
      $display("FAIL swap: top=%h next=%h count=%0d, want 11 22 2", stack_top, stack_next, count);
    end
    issue(4'd13, 8'hFF);
    n_cmp++;
    if (err_illegal !== 1'b1 || stack_top !== 8'h11 || stack_next !== 8'h22 || count !== 3'd2) begin
      n_bad++;
      $display("FAIL illegal_op: illegal=%b top=%h next=%h count=%0d, want 1 11 22 2",
               err_illegal, stack_top, stack_next, count);
    end
    issue(OP_CLEAR, 8'h00);
    n_cmp++;
    if ({err_over, err_under, err_ovf, err_illegal} !== 4'b0000 || count !== 3'd0 || stack_top !== 8'h00) begin
      n_bad++;
      $display("FAIL clear_all: flags=%b%b%b%b count=%0d top=%h, want 0000 0 00",
               err_over, err_under, err_ovf, err_illegal, count, stack_top);
    end
    issue(OP_DUP, 8'h00);
    n_cmp++;
    if (err_under !== 1'b1 || err_over !== 1'b0 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL dup_empty: under=%b over=%b count=%0d, want 1 0 0", err_under, err_over, count);
    end
    issue(OP_CLEAR, 8'h00);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = OP_PUSH;
    data_in   = 8'h10;
    @(negedge clk);
    data_in = 8'h20;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || count !== 3'd1 || stack_top !== 8'h10) begin
      n_bad++;
      $display("FAIL back_to_back: done=%b count=%0d top=%h, want 1 1 10", done, count, stack_top);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (count !== 3'd1 || stack_top !== 8'h10 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL back_to_back_late: count=%0d top=%h ready=%b, want 1 10 1", count, stack_top, ready);
    end
  endtask

  task automatic test_reset_abort;
    issue(OP_CLEAR, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = OP_PUSH;
    data_in   = 8'h33;
    @(negedge clk);
    cmd_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || stack_top !== 8'h00 || done !== 1'b0 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_abort: count=%0d top=%h done=%b ready=%b, want 0 00 0 1",
               count, stack_top, done, ready);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || count !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_abort_late: done=%b count=%0d, want 0 0", done, count);
    end
    issue(OP_PUSH, 8'h44);
    n_cmp++;
    if (stack_top !== 8'h44 || count !== 3'd1 || stack_next !== 8'h00) begin
      n_bad++;
      $display("FAIL after_abort: top=%h count=%0d next=%h, want 44 1 00", stack_top, count, stack_next);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_arith();
    test_bounds();
    test_swap_illegal();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
